light_actuator: RTL and testbench

Sequential actuator stage driven by the lighting decision logic. It accepts a target lamp pattern and window-shade level through a valid/ready handshake. It then slews the physical outputs toward the target: one lamp toggles at a time to limit inrush, and the shade motor moves one level at a time. It emits a one-cycle `done` when the outputs match the target. It sits between the combinational lighting decision block (`lightstate`/`wshade` producers) and the room I/O pins.

---
 rtl/light_actuator.sv | 111 +++++++++++
 tb/tb_light_actuator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/light_actuator.sv
// light_actuator: slews a 16-lamp bank and a 16-level window shade toward a
// requested target. Lamps change one at a time to limit inrush current, and the
// shade moves one level per step. A one-cycle done pulse marks completion.
module light_actuator #(
  parameter int LAMP_GAP    = 2,
  parameter int STEP_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [15:0] req_lightstate,
  input  logic [3:0]  req_wshade,
  output logic [15:0] lamp_on,
  output logic [3:0]  shade_pos,
  output logic        busy,
  output logic        done
);

  // Each timer is wide enough to hold its parameter minus one; a parameter of
  // 1 still needs a 1-bit counter that wraps on every edge.
  localparam int LW = (LAMP_GAP > 1) ? $clog2(LAMP_GAP) : 1;
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [LW-1:0] LAMP_LAST  = LW'(LAMP_GAP - 1);
  localparam logic [SW-1:0] SHADE_LAST = SW'(STEP_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_APPLY = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state;
  logic [15:0]   tgt_l;
  logic [3:0]    tgt_s;
  logic [LW-1:0] lamp_cnt;
  logic [SW-1:0] shade_cnt;

  logic          lamp_wrap;
  logic          shade_wrap;
  logic          matched;
  logic [15:0]   lamp_diff;
  logic [15:0]   lamp_pick;

  // Isolate the lowest differing lamp bit (two's-complement trick) and decode
  // timer wraps and the "outputs already at target" condition.
  always_comb begin
    lamp_diff  = lamp_on ^ tgt_l;
    lamp_pick  = lamp_diff & (~lamp_diff + 16'd1);
    lamp_wrap  = (lamp_cnt == LAMP_LAST);
    shade_wrap = (shade_cnt == SHADE_LAST);
    matched    = (lamp_diff == 16'd0) && (shade_pos == tgt_s);
  end

  // Status outputs come straight from the state register; reset masks them so
  // nothing looks ready or busy while rst is held.
  always_comb begin
    req_ready = (state == S_IDLE) && !rst;
    busy      = (state == S_APPLY) && !rst;
    done      = (state == S_DONE) && !rst;
  end

  // Control FSM plus the two slew engines; the timers free-run through APPLY
  // so lamp and shade progress stay on their own fixed cadences.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      tgt_l     <= 16'd0;
      tgt_s     <= 4'd0;
      lamp_cnt  <= '0;
      shade_cnt <= '0;
      lamp_on   <= 16'd0;
      shade_pos <= 4'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            tgt_l     <= req_lightstate;
            tgt_s     <= req_wshade;
            lamp_cnt  <= '0;
            shade_cnt <= '0;
            state     <= S_APPLY;
          end
        end
        S_APPLY: begin
          lamp_cnt  <= lamp_wrap ? '0 : lamp_cnt + LW'(1);
          shade_cnt <= shade_wrap ? '0 : shade_cnt + SW'(1);
          if (matched) begin
            state <= S_DONE;
          end else begin
            if (lamp_wrap) begin
              lamp_on <= lamp_on ^ lamp_pick;
            end
            if (shade_wrap) begin
              if (shade_pos < tgt_s) begin
                shade_pos <= shade_pos + 4'd1;
              end else if (shade_pos > tgt_s) begin
                shade_pos <= shade_pos - 4'd1;
              end
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_actuator.sv
// tb_light_actuator: directed stimulus with a scoreboard of per-cycle expected
// outputs, filled from a cycle-indexed reference model when a request is sent.
module tb_light_actuator;

  localparam int LAMP_GAP    = 2;
  localparam int STEP_CYCLES = 4;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [15:0] req_lightstate;
  logic [3:0]  req_wshade;
  logic [15:0] lamp_on;
  logic [3:0]  shade_pos;
  logic        busy;
  logic        done;

  typedef struct {
    string       tag;
    logic [15:0] lamp;
    logic [3:0]  shade;
    logic        busy;
    logic        done;
    logic        ready;
  } exp_t;

  exp_t        sb_q[$];
  int          vectors;
  int          miscompares;
  int          req_id;
  logic [15:0] m_lamp;
  logic [3:0]  m_shade;

  light_actuator #(
    .LAMP_GAP   (LAMP_GAP),
    .STEP_CYCLES(STEP_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_lightstate(req_lightstate),
    .req_wshade    (req_wshade),
    .lamp_on       (lamp_on),
    .shade_pos     (shade_pos),
    .busy          (busy),
    .done          (done)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pushExp(input string tag, input logic b, input logic d, input logic r);
    exp_t e;
    e.tag   = tag;
    e.lamp  = m_lamp;
    e.shade = m_shade;
    e.busy  = b;
    e.done  = d;
    e.ready = r;
    sb_q.push_back(e);
  endtask

  // Reference model: walks edges after the accept edge, toggling lamps on
  // multiples of LAMP_GAP and stepping the shade on multiples of STEP_CYCLES.
  task automatic pushModel(input logic [15:0] tl, input logic [3:0] ts);
    int  e;
    bit  fin;
    bit  found;
    req_id++;
    pushExp($sformatf("r%0d.E0", req_id), 1'b1, 1'b0, 1'b0);
    e   = 1;
    fin = 0;
    while (!fin) begin
      if (m_lamp == tl && m_shade == ts) begin
        pushExp($sformatf("r%0d.E%0d.done", req_id, e), 1'b0, 1'b1, 1'b0);
        pushExp($sformatf("r%0d.E%0d.idle", req_id, e + 1), 1'b0, 1'b0, 1'b1);
        fin = 1;
      end else begin
        if (e % LAMP_GAP == 0) begin
          found = 0;
          for (int i = 0; i < 16; i++) begin
            if (!found && m_lamp[i] != tl[i]) begin
              m_lamp[i] = tl[i];
              found = 1;
            end
          end
        end
        if (e % STEP_CYCLES == 0) begin
          if (m_shade < ts) m_shade = m_shade + 4'd1;
          else if (m_shade > ts) m_shade = m_shade - 4'd1;
        end
        pushExp($sformatf("r%0d.E%0d", req_id, e), 1'b1, 1'b0, 1'b0);
        e++;
      end
    end
  endtask

  // Present a request in the current IDLE cycle, let the accept edge pass,
  // then queue the expected trajectory.
  task automatic applyStimulus(input logic [15:0] tl, input logic [3:0] ts);
    req_lightstate = tl;
    req_wshade     = ts;
    req_valid      = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pushModel(tl, ts);
  endtask

  // Pop one scoreboard entry and compare every output against it
  task automatic checkOutput();
    exp_t e;
    if (sb_q.size() == 0) begin
      cmp("scoreboard_empty", 16'd1, 16'd0);
    end else begin
      e = sb_q.pop_front();
      cmp({e.tag, ".lamp_on"},   lamp_on,          e.lamp);
      cmp({e.tag, ".shade_pos"}, {12'd0, shade_pos}, {12'd0, e.shade});
      cmp({e.tag, ".busy"},      {15'd0, busy},      {15'd0, e.busy});
      cmp({e.tag, ".done"},      {15'd0, done},      {15'd0, e.done});
      cmp({e.tag, ".req_ready"}, {15'd0, req_ready}, {15'd0, e.ready});
    end
  endtask

  // Compare the entry for the current cycle, then one per following edge
  task automatic drainQueue(input int max_entries);
    int n;
    n = 0;
    if (sb_q.size() > 0 && n < max_entries) begin
      checkOutput();
      n++;
    end
    while (sb_q.size() > 0 && n < max_entries) begin
      @(posedge clk);
      #1;
      checkOutput();
      n++;
    end
  endtask

  // Directed scenario sequence
  initial begin
    vectors        = 0;
    miscompares    = 0;
    req_id         = 0;
    m_lamp         = 16'd0;
    m_shade        = 4'd0;
    rst            = 1'b1;
    req_valid      = 1'b0;
    req_lightstate = 16'd0;
    req_wshade     = 4'd0;

    // Reset held three cycles with random inputs
    for (int c = 0; c < 3; c++) begin
      req_valid      = 1'($urandom);
      req_lightstate = 16'($urandom);
      req_wshade     = 4'($urandom);
      @(posedge clk);
      #1;
      cmp($sformatf("rst%0d.lamp_on", c),   lamp_on,               16'd0);
      cmp($sformatf("rst%0d.shade_pos", c), {12'd0, shade_pos},    16'd0);
      cmp($sformatf("rst%0d.busy", c),      {15'd0, busy},         16'd0);
      cmp($sformatf("rst%0d.done", c),      {15'd0, done},         16'd0);
      cmp($sformatf("rst%0d.req_ready", c), {15'd0, req_ready},    16'd0);
    end
    rst       = 1'b0;
    req_valid = 1'b0;
    #1;
    cmp("release.req_ready", {15'd0, req_ready}, 16'd1);
    @(posedge clk);
    #1;
    cmp("idle.req_ready", {15'd0, req_ready}, 16'd1);
    cmp("idle.busy",      {15'd0, busy},      16'd0);

    // Null request
    applyStimulus(16'h0000, 4'd0);
    drainQueue(1000);

    // Shade slew up to 3 then back to 1
    applyStimulus(16'h0000, 4'd3);
    drainQueue(1000);
    cmp("shade_up.final", {12'd0, shade_pos}, 16'd3);
    applyStimulus(16'h0000, 4'd1);
    drainQueue(1000);

    // Lamp ordering, lowest index first, on and off alike
    applyStimulus(16'h8005, 4'd1);
    drainQueue(1000);
    cmp("lamp_order.final", lamp_on, 16'h8005);
    applyStimulus(16'h0004, 4'd1);
    drainQueue(1000);

    // Return to all-off, shade 0
    applyStimulus(16'h0000, 4'd0);
    drainQueue(1000);

    // Mixed engines with a request held during APPLY
    applyStimulus(16'h0003, 4'd1);
    req_lightstate = 16'h00F0;
    req_wshade     = 4'd2;
    req_valid      = 1'b1;
    drainQueue(1000);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    pushModel(16'h00F0, 4'd2);
    drainQueue(1000);

    // Reset in the middle of a long shade move
    applyStimulus(16'h0000, 4'd15);
    drainQueue(10);
    sb_q.delete();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cmp("midrst.shade_pos", {12'd0, shade_pos}, 16'd0);
    cmp("midrst.lamp_on",   lamp_on,            16'd0);
    cmp("midrst.busy",      {15'd0, busy},      16'd0);
    cmp("midrst.done",      {15'd0, done},      16'd0);
    m_lamp  = 16'd0;
    m_shade = 4'd0;
    rst     = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      #1;
      cmp($sformatf("postrst%0d.done", c),      {15'd0, done},      16'd0);
      cmp($sformatf("postrst%0d.req_ready", c), {15'd0, req_ready}, 16'd1);
    end
    applyStimulus(16'h0002, 4'd1);
    drainQueue(1000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
